key_cmd_gen: RTL

//  Front-panel input stage sitting directly upstream of counter_down.

---
 rtl/key_cmd_gen_pkg.sv | 34 +++
 rtl/key_debounce.sv | 52 +++++
 rtl/key_cmd_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/key_cmd_gen_pkg.sv
// Shared constants for the front-panel key stage: one-hot digit selects,
// default debounce/repeat timing, key indices and the run-state encoding.
package key_cmd_gen_pkg;

    localparam logic [2:0] SEL_UNITS    = 3'b001;
    localparam logic [2:0] SEL_TENS     = 3'b010;
    localparam logic [2:0] SEL_HUNDREDS = 3'b100;

    localparam int DEF_DEB_CYCLES    = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 5_000_000;

    localparam int NUM_KEYS  = 5;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_SEL   = 2;
    localparam int KEY_START = 3;
    localparam int KEY_RST   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Digit rotation units -> tens -> hundreds -> units; illegal codes recover to units.
    function automatic logic [2:0] sel_next(input logic [2:0] cur);
        case (cur)
            SEL_UNITS: return SEL_TENS;
            SEL_TENS:  return SEL_HUNDREDS;
            default:   return SEL_UNITS;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser followed by a debounce counter.
// held is the debounced level (1 = pressed); press is a one-cycle pulse on
// the debounced released->pressed transition.
module key_debounce
    import key_cmd_gen_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic key_n,
    output logic held,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Synchronise, count consecutive disagreeing cycles, flip the stable level on the last one.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            press_q <= 1'b0;
            if (sync_q2 == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
                press_q  <= ~sync_q2;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign held  = ~stable_q;
    assign press = press_q;

endmodule

// File: rtl/key_cmd_gen.sv
// Front-panel command generator feeding counter_down: debounced key presses
// become one-hot inc/dec pulses (with hold-to-repeat), start/reset pulses,
// the run level and the selected digit.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | counter stopped; up/down/sel editing allowed, start accepted
//  ST_RUN  | counter running; editing locked out, only rst leaves
module key_cmd_gen
    import key_cmd_gen_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_sel_n,
    input  logic       key_start_n,
    input  logic       key_rst_n,
    output logic [2:0] cnt_inc,
    output logic [2:0] cnt_dec,
    output logic       cnt_down,
    output logic       start_flag,
    output logic       reset_flag,
    output logic [2:0] sel
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    // Loads are one short because the terminal cycle itself counts as a timer cycle.
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] raw_n;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] press;
    logic                unused_held;

    run_state_t    state_q;
    run_state_t    state_d;
    logic          rep_armed_q;
    logic [RW-1:0] rep_tmr_q;
    logic          edit_ok;
    logic          rep_hit;
    logic          up_fire;
    logic          dn_fire;
    logic          start_d;
    logic          reset_d;

    assign raw_n = {key_rst_n, key_start_n, key_sel_n, key_down_n, key_up_n};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .Clk    (Clk),
            .Reset_n(Reset_n),
            .key_n  (raw_n[i]),
            .held   (held[i]),
            .press  (press[i])
        );
    end

    // sel/start/rst act only on their press pulse; their levels are not needed.
    assign unused_held = ^held[KEY_RST:KEY_SEL];

    // Decide whether an up/down pulse goes out this cycle (press or repeat tick).
    always_comb begin
        edit_ok = (state_q == ST_IDLE) && !(held[KEY_UP] && held[KEY_DOWN]);
        rep_hit = rep_armed_q && (rep_tmr_q == '0);
        up_fire = edit_ok && (press[KEY_UP]   || (rep_hit && held[KEY_UP]));
        dn_fire = edit_ok && (press[KEY_DOWN] || (rep_hit && held[KEY_DOWN]));
    end

    // Repeat down-counter: armed by a press, reloaded on each tick, cleared when editing stops.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rep_armed_q <= 1'b0;
            rep_tmr_q   <= '0;
        end else if (!edit_ok || !(held[KEY_UP] || held[KEY_DOWN])) begin
            rep_armed_q <= 1'b0;
            rep_tmr_q   <= '0;
        end else if (press[KEY_UP] || press[KEY_DOWN]) begin
            rep_armed_q <= 1'b1;
            rep_tmr_q   <= DELAY_LOAD;
        end else if (rep_hit) begin
            rep_tmr_q <= PERIOD_LOAD;
        end else if (rep_tmr_q != '0) begin
            rep_tmr_q <= rep_tmr_q - RW'(1);
        end
    end

    // Run-state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run-state transitions; rst always wins over a simultaneous start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!press[KEY_RST] && press[KEY_START]) state_d = ST_RUN;
            ST_RUN:  if (press[KEY_RST]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Run-state outputs: run level plus the start/reset pulse requests.
    always_comb begin
        cnt_down = (state_q == ST_RUN);
        reset_d  = press[KEY_RST];
        start_d  = (state_q == ST_IDLE) && !press[KEY_RST] && press[KEY_START];
    end

    // Registered command outputs and digit selection; pulses use the pre-rotation sel.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_inc    <= '0;
            cnt_dec    <= '0;
            start_flag <= 1'b0;
            reset_flag <= 1'b0;
            sel        <= SEL_UNITS;
        end else begin
            cnt_inc    <= up_fire ? sel : 3'b000;
            cnt_dec    <= dn_fire ? sel : 3'b000;
            start_flag <= start_d;
            reset_flag <= reset_d;
            if (press[KEY_RST]) begin
                sel <= SEL_UNITS;
            end else if (press[KEY_SEL] && (state_q == ST_IDLE)) begin
                sel <= sel_next(sel);
            end
        end
    end

endmodule
